// File: rtl/mul_share_arb_if.sv
// Request/response bundle for the shared multiplier; master = requesters + product sink, slave = arbiter.
// Widths follow the arbiter parameters; requester i occupies req_a/req_b bits [i*DW +: DW].
interface mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int PW   = 32,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [PW-1:0]      rsp_p;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin shared signed DWxDW multiplier, 2-cycle latency; a stalled response freezes the whole pipe
// and blocks new grants. Optional perf counters under MUL_SHARE_ARB_PERF_EN.
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int PW   = 32,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  mul_share_arb_if.slave bus
`ifdef MUL_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]    perf_busy_cnt,
  output logic [31:0]    perf_stall_cnt
`endif
);

  localparam int CW = IDW + 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } s0_t;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [PW-1:0]  p;
  } s1_t;

  s0_t             s0_q, s0_d;
  s1_t             s1_q, s1_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            ce;
  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic [CW-1:0]   cand_w;
  logic [CW-1:0]   nxt_w;
  logic [NREQ-1:0] ready_vec;
  logic            accept;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;

  assign ce = !(s1_q.vld && !bus.rsp_ready);

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_w    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_w = {1'b0, rr_ptr_q} + CW'(k);
      if (cand_w >= CW'(NREQ)) begin
        cand_w = cand_w - CW'(NREQ);
      end
      if (!grant_vld && bus.req_valid[cand_w[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand_w[IDW-1:0];
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (NREQ == 1) begin
      ready_vec[0] = ce && !reset;
    end else if (ce && !reset && grant_vld) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign accept = |(bus.req_valid & ready_vec);

  always_comb begin
    nxt_w = {1'b0, grant_idx} + CW'(1);
    if (nxt_w >= CW'(NREQ)) begin
      nxt_w = '0;
    end
  end

  // Sign-extend before multiplying so the full PW-bit product is kept.
  always_comb begin
    a_ext = PW'($signed(s0_q.a));
    b_ext = PW'($signed(s0_q.b));
  end

  always_comb begin
    s0_d     = s0_q;
    s1_d     = s1_q;
    rr_ptr_d = rr_ptr_q;
    if (ce) begin
      s0_d.vld = accept;
      if (accept) begin
        s0_d.id  = grant_idx;
        s0_d.a   = bus.req_a[grant_idx*DW +: DW];
        s0_d.b   = bus.req_b[grant_idx*DW +: DW];
        rr_ptr_d = nxt_w[IDW-1:0];
      end
      s1_d.vld = s0_q.vld;
      s1_d.id  = s0_q.id;
      s1_d.p   = a_ext * b_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q     <= '0;
      s1_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = s1_q.vld;
  assign bus.rsp_id    = s1_q.id;
  assign bus.rsp_p     = s1_q.p;
  assign bus.busy      = s0_q.vld | s1_q.vld;

`ifdef MUL_SHARE_ARB_PERF_EN
  logic [31:0] perf_busy_cnt_q, perf_busy_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_busy_cnt_d  = perf_busy_cnt_q + {31'd0, bus.busy};
    perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, !ce};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_cnt_q  <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_busy_cnt_q  <= perf_busy_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_busy_cnt  = perf_busy_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one pipelined signed 16x16 multiplier datapath among NREQ requesters in the hls4ml kernel.
- Round-robin arbitration over valid/ready request channels.
- Requester ID is tracked alongside operands through the pipeline.
- Returns each product on a single response channel tagged with the requester ID, with backpressure implemented as a pipeline clock-enable.

Parameters:
- NREQ, 4, number of requesters (1..16).
- DW, 16, operand width, signed two's complement.
- PW, 32, product width; must equal 2*DW.
- IDW, 2, response ID width; must equal max(1, clog2(NREQ)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*DW  operand A; requester i occupies bits [i*DW +: DW].
- req_b  in  NREQ*DW  operand B; same packing as req_a.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  downstream accepts product.
- rsp_id  out  IDW  index of the requester that owns rsp_p.
- rsp_p  out  PW  signed product.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - rr_ptr = 0.
  - Stage-0 and stage-1 valid bits = 0.
  - rsp_valid = 0, rsp_p = 0, rsp_id = 0, busy = 0.
  - req_ready = 0 while reset is high.
  - Reset asserted mid-operation discards all in-flight products; no response is emitted for them.
- Pipeline enable: ce = !(rsp_valid && !rsp_ready).
  - When ce = 0, every pipeline register holds: operands, IDs, valid bits, product.
  - When ce = 0, req_ready = 0.
- Arbitration (combinational, evaluated when ce = 1):
  - grant = first index i with req_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[grant] = 1; all other bits = 0.
  - No valid requests -> req_ready = 0.
  - req_ready does not depend on req_a or req_b.
- Acceptance: req_valid[i] && req_ready[i].
  - Stage 0 captures a, b, id=i and sets s0_valid = 1.
  - rr_ptr <= (i+1) mod NREQ.
  - No acceptance (with ce = 1): s0_valid <= 0 and rr_ptr holds.
- Stage 1 (the multiplier register), when ce = 1:
  - s1_p <= signed(s0_a) * signed(s0_b), full PW bits, no truncation or saturation.
  - s1_id <= s0_id; s1_valid <= s0_valid.
  - Stage-1 registers drive rsp_p, rsp_id and rsp_valid directly.
- Latency and throughput:
  - A request accepted in cycle t has rsp_valid = 1 in cycle t+2 if no stall occurs.
  - Each stall cycle adds exactly one cycle.
  - Sustained throughput is one product per cycle while rsp_ready = 1.
- Response hold: while rsp_valid = 1 and rsp_ready = 0, rsp_p and rsp_id stay stable and no request is accepted.
  - Exactly two products may be in flight; none are lost or duplicated.
- Extreme operands: (-32768)*(-32768) = 1073741824, which fits in PW = 32.
- busy = s0_valid | s1_valid.
- NREQ = 1: the arbiter degenerates to req_ready[0] = ce && !reset; rsp_id = 0 always.
- Ordering: responses leave in acceptance order. There is no per-requester reordering.

Optional Feature:
- Macro: MUL_SHARE_ARB_PERF_EN.
- When defined, the block adds output perf_busy_cnt (32 bits) and output perf_stall_cnt (32 bits).
  - perf_busy_cnt increments every cycle in which busy = 1.
  - perf_stall_cnt increments every cycle in which ce = 0.
  - Both counters wrap at 2^32, reset to 0, and have no other clear.
- When not defined: neither port exists, there is no counter logic, and all other behaviour is identical.

Test Plan:
- Reset then idle: all req_valid = 0 for 10 cycles -> rsp_valid = 0, busy = 0, req_ready = 0.
- Single request: requester 2 presents a=300, b=-7 in cycle 5 -> req_ready = 0100b in cycle 5; rsp_valid = 1 in cycle 7 with rsp_p = -2100, rsp_id = 2.
- Fairness: all four requesters hold valid continuously, rsp_ready = 1 -> grant order 0,1,2,3,0,1,... one per cycle; responses return in the same order, each with the correct product.
- Backpressure: two requests in flight, then rsp_ready = 0 for 5 cycles -> rsp_p and rsp_id stable, req_ready = 0 throughout; after release both products emerge on consecutive cycles, no loss.
- Extremes: a=-32768, b=-32768 -> 1073741824; a=-32768, b=32767 -> -1073709056; a=0, b=-1 -> 0.
- Reset mid-flight: assert reset for one cycle with 2 products in flight -> no rsp_valid afterward, rr_ptr = 0 (next grant goes to requester 0 when all are valid), and the perf counters (if compiled in) read 0.
